// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with a generic operand width and a per-operation signed/unsigned mode.
// One Booth step per cycle on (WIDTH+1)-bit extended operands, so a result appears WIDTH+1 cycles after start.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] res
);

    localparam int EW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [EW-1:0]        r_acc;
    logic [EW-1:0]        r_q;
    logic [EW-1:0]        r_m;
    logic                 r_qm1;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_res;
    logic [EW-1:0]        w_sum;
    logic [EW-1:0]        w_acc_nx;
    logic [EW-1:0]        w_q_nx;
    logic [2*WIDTH-1:0]   w_res_nx;
    logic                 w_last;

    // The extra top bit lets unsigned operands run through the signed Booth recoding as non-negative values.
    function automatic logic [EW-1:0] ext_op(input logic [WIDTH-1:0] v, input logic sm);
        return {sm & v[WIDTH-1], v};
    endfunction

    // Booth add/subtract, arithmetic shift and the low half of the post-shift product.
    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
        w_acc_nx = {w_sum[EW-1], w_sum[EW-1:1]};
        w_q_nx   = {w_sum[0], r_q[EW-1:1]};
        // Low 2*WIDTH bits of the shifted {A,Q}: A contributes its low WIDTH-1 bits.
        w_res_nx = {w_sum[WIDTH-1:0], r_q[WIDTH:1]};
        w_last   = (r_cnt == CW'(WIDTH));
    end

    // Next-state decode.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_CALC;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_CALC;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= {EW{1'b0}};
            r_q    <= {EW{1'b0}};
            r_m    <= {EW{1'b0}};
            r_qm1  <= 1'b0;
            r_cnt  <= {CW{1'b0}};
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_res  <= {(2*WIDTH){1'b0}};
        end else begin
            r_busy <= (w_state_nx != S_IDLE);
            r_done <= (w_state_nx == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc <= {EW{1'b0}};
                        r_q   <= ext_op(b, signed_mode);
                        r_m   <= ext_op(a, signed_mode);
                        r_qm1 <= 1'b0;
                        r_cnt <= {CW{1'b0}};
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nx;
                    r_q   <= w_q_nx;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (w_last) begin
                        r_res <= w_res_nx;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign res  = r_res;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: a WIDTH=4 and a WIDTH=8 instance, vector table plus protocol/reset sequences.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = 4'd0, b4 = 4'd0;
    logic        busy4, done4;
    logic [7:0]  res4;
    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic        busy8, done8;
    logic [15:0] res8;

    int errors = 0;
    int checks = 0;

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .signed_mode(sm4), .busy(busy4), .done(done4), .res(res4)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .signed_mode(sm8), .busy(busy8), .done(done8), .res(res8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w8;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cur_done(input logic w8);
        return w8 ? done8 : done4;
    endfunction

    function automatic logic cur_busy(input logic w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic logic [15:0] cur_res(input logic w8);
        return w8 ? res8 : {8'd0, res4};
    endfunction

    // One pulsed-start operation: checks busy, latency to done, result, and the return to idle.
    task automatic run_op(input logic w8, input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input logic [15:0] exp, input string name);
        int cyc;
        int lat;
        lat = w8 ? 9 : 5;
        @(negedge clk);
        if (w8) begin
            a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; start4 = 1'b1;
        end
        @(posedge clk); #1;
        start4 = 1'b0; start8 = 1'b0;
        chk({name, " busy_after_start"}, {31'd0, cur_busy(w8)}, 32'd1);
        cyc = 0;
        while (!cur_done(w8) && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (!cur_done(w8)) begin
                chk({name, " busy_in_calc"}, {31'd0, cur_busy(w8)}, 32'd1);
            end
        end
        chk({name, " latency"}, cyc, lat);
        chk({name, " res"}, {16'd0, cur_res(w8)}, {16'd0, exp});
        @(posedge clk); #1;
        chk({name, " done_fall"}, {31'd0, cur_done(w8)}, 32'd0);
        chk({name, " busy_fall"}, {31'd0, cur_busy(w8)}, 32'd0);
    endtask

    initial begin
        vec_t vecs[12];
        int   done_at[3];
        int   nd;
        int   cyc;

        vecs[0]  = '{1'b0, 8'h05, 8'h0A, 1'b1, 16'h00E2};
        vecs[1]  = '{1'b0, 8'h0D, 8'h0E, 1'b1, 16'h0006};
        vecs[2]  = '{1'b0, 8'h09, 8'h0F, 1'b1, 16'h0007};
        vecs[3]  = '{1'b0, 8'h0D, 8'h09, 1'b1, 16'h0015};
        vecs[4]  = '{1'b0, 8'h08, 8'h08, 1'b1, 16'h0040};
        vecs[5]  = '{1'b0, 8'h0F, 8'h0F, 1'b0, 16'h00E1};
        vecs[6]  = '{1'b0, 8'h0A, 8'h03, 1'b0, 16'h001E};
        vecs[7]  = '{1'b0, 8'h0F, 8'h0F, 1'b1, 16'h0001};
        vecs[8]  = '{1'b0, 8'h0A, 8'h03, 1'b1, 16'h00EE};
        vecs[9]  = '{1'b1, 8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[10] = '{1'b1, 8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[11] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 16'h0001};

        #12;
        chk("reset busy4", {31'd0, busy4}, 32'd0);
        chk("reset done4", {31'd0, done4}, 32'd0);
        chk("reset res4", {24'd0, res4}, 32'd0);
        chk("reset res8", {16'd0, res8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].w8, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp,
                   $sformatf("vec%0d", i));
        end

        // Starts during CALC and during DONE must be ignored.
        @(negedge clk);
        a4 = 4'd5; b4 = 4'hA; sm4 = 1'b1; start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ign done", {31'd0, done4}, 32'd1);
        chk("ign res", {24'd0, res4}, 32'hE2);
        a4 = 4'd3; b4 = 4'd3; start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        chk("ign done_fall", {31'd0, done4}, 32'd0);
        chk("ign busy_dropped", {31'd0, busy4}, 32'd0);
        @(posedge clk); #1;
        chk("ign still_idle", {31'd0, busy4}, 32'd0);
        chk("ign res_kept", {24'd0, res4}, 32'hE2);

        // Start held high: results every WIDTH+3 = 7 cycles.
        @(negedge clk);
        a4 = 4'd2; b4 = 4'd3; sm4 = 1'b0; start4 = 1'b1;
        nd = 0;
        cyc = 0;
        while (nd < 3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done4) begin
                done_at[nd] = cyc;
                nd++;
                chk("b2b res", {24'd0, res4}, 32'd6);
            end
        end
        chk("b2b count", nd, 3);
        if (nd == 3) begin
            chk("b2b first", done_at[0], 6);
            chk("b2b gap1", done_at[1] - done_at[0], 7);
            chk("b2b gap2", done_at[2] - done_at[1], 7);
        end
        @(negedge clk); start4 = 1'b0;
        cyc = 0;
        while (busy4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b drain", {31'd0, busy4}, 32'd0);

        // Asynchronous reset in the middle of CALC.
        run_op(1'b0, 8'h07, 8'h07, 1'b0, 16'h0031, "pre_rst");
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd6; sm4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst busy", {31'd0, busy4}, 32'd0);
        chk("arst done", {31'd0, done4}, 32'd0);
        chk("arst res", {24'd0, res4}, 32'd0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst_n = 1'b1;
            if (done4) nd++;
        end
        chk("arst no_done", nd, 0);
        chk("arst res_after", {24'd0, res4}, 32'd0);
        run_op(1'b0, 8'h03, 8'h03, 1'b1, 16'h0009, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
